alu_muldiv: RTL and testbench

- Parametrised next-generation execute-stage ALU for the pipelined MIPS core.
- Keeps all single-cycle integer ops (combinational result) and adds a sequential multiply/divide unit with architectural HI/LO registers.
- Adds a stall handshake to the hazard unit and two new single-cycle ops, SLTU and LUI.
- Sits in EX; `res` feeds the EX/MEM register, and `stall` freezes IF/ID/EX.

---
 rtl/alu_muldiv_if.sv | 29 ++
 rtl/alu_muldiv.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Operand/result bundle between the EX stage and alu_muldiv.
// The master drives the instruction fields; the slave returns the result, stall and HI/LO.
interface alu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic [4:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, op, in1, in2, shamt,
        input  res, stall, busy, done, hi, lo
    );

    modport slave (
        input  in_valid, op, in1, in2, shamt,
        output res, stall, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with a sequential multiply/divide unit and HI/LO registers.
// Defining ALU_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    alu_muldiv_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [4:0] OpAdd   = 5'h01;
    localparam logic [4:0] OpAnd   = 5'h02;
    localparam logic [4:0] OpOr    = 5'h03;
    localparam logic [4:0] OpSub   = 5'h04;
    localparam logic [4:0] OpSll   = 5'h05;
    localparam logic [4:0] OpSrl   = 5'h06;
    localparam logic [4:0] OpSra   = 5'h07;
    localparam logic [4:0] OpSlt   = 5'h08;
    localparam logic [4:0] OpNor   = 5'h09;
    localparam logic [4:0] OpSllv  = 5'h0A;
    localparam logic [4:0] OpSrlv  = 5'h0B;
    localparam logic [4:0] OpSrav  = 5'h0C;
    localparam logic [4:0] OpXor   = 5'h0D;
    localparam logic [4:0] OpSltu  = 5'h0E;
    localparam logic [4:0] OpLui   = 5'h0F;
    localparam logic [4:0] OpMfhi  = 5'h14;
    localparam logic [4:0] OpMflo  = 5'h15;
    localparam logic [4:0] OpMthi  = 5'h16;
    localparam logic [4:0] OpMtlo  = 5'h17;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic             is_div_q, is_div_d;
    logic             done_q, done_d;

    logic             busy;
    logic             is_md;
    logic             is_md_start;
    logic             accept;
    logic             sgn;
    logic             in1_neg;
    logic             in2_neg;
    logic [WIDTH-1:0] in1_mag;
    logic [WIDTH-1:0] in2_mag;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_sgn;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res;

    assign busy        = (state_q != StIdle);
    assign is_md       = (bus.op[4:3] == 2'b10);   // 0x10..0x17
    assign is_md_start = (bus.op[4:2] == 3'b100);  // 0x10..0x13
    assign accept      = bus.in_valid && is_md_start && !busy;

    // Even codes (MULT, DIV) are signed; the sequencer works on magnitudes.
    assign sgn     = ~bus.op[0];
    assign in1_neg = sgn & bus.in1[WIDTH-1];
    assign in2_neg = sgn & bus.in2[WIDTH-1];
    assign in1_mag = in1_neg ? -bus.in1 : bus.in1;
    assign in2_mag = in2_neg ? -bus.in2 : bus.in2;

    // Restoring division: shift the next dividend bit into the partial remainder.
    assign div_rem  = {acc_q, b_q[WIDTH-1]};
    assign div_diff = div_rem - {1'b0, a_q};
    assign div_ge   = (div_rem >= {1'b0, a_q});

    assign prod_mag = {acc_q, b_q};
    assign prod_sgn = neg_res_q ? -prod_mag : prod_mag;
    assign quo      = neg_res_q ? -b_q : b_q;
    assign rem      = neg_rem_q ? -acc_q : acc_q;

`ifdef ALU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`else
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        in1_d     = in1_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        is_div_d  = is_div_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d       = in2_mag;
                    b_d       = in1_mag;
                    acc_d     = '0;
                    cnt_d     = '0;
                    in1_d     = bus.in1;
                    is_div_d  = bus.op[1];
                    neg_res_d = in1_neg ^ in2_neg;
                    neg_rem_d = in1_neg;
                    div0_d    = (bus.in2 == '0);
                    state_d   = bus.op[1] ? StDiv : StMul;
                end else if (bus.in_valid && bus.op == OpMthi) begin
                    hi_d = bus.in1;
                end else if (bus.in_valid && bus.op == OpMtlo) begin
                    lo_d = bus.in1;
                end
            end
            StMul: begin
`ifdef ALU_FAST_MUL_EN
                {acc_d, b_d} = fast_prod;
                state_d      = StFin;
`else
                // Product accumulates in {acc, b}; the multiplier shifts out of b.
                acc_d = mul_sum[WIDTH:1];
                b_d   = {mul_sum[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = StFin;
                end
`endif
            end
            StDiv: begin
                acc_d = div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0];
                b_d   = {b_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                if (!is_div_q) begin
                    hi_d = prod_sgn[2*WIDTH-1:WIDTH];
                    lo_d = prod_sgn[WIDTH-1:0];
                end else if (div0_q) begin
                    hi_d = in1_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            in1_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            is_div_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            in1_q     <= in1_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            is_div_q  <= is_div_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        res = '0;
        case (bus.op)
            OpAdd:   res = bus.in1 + bus.in2;
            OpAnd:   res = bus.in1 & bus.in2;
            OpOr:    res = bus.in1 | bus.in2;
            OpSub:   res = bus.in1 - bus.in2;
            OpSll:   res = bus.in2 << bus.shamt;
            OpSrl:   res = bus.in2 >> bus.shamt;
            OpSra:   res = $signed(bus.in2) >>> bus.shamt;
            OpSlt:   res = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
            OpNor:   res = ~(bus.in1 | bus.in2);
            OpSllv:  res = bus.in2 << bus.in1[SHW-1:0];
            OpSrlv:  res = bus.in2 >> bus.in1[SHW-1:0];
            OpSrav:  res = $signed(bus.in2) >>> bus.in1[SHW-1:0];
            OpXor:   res = bus.in1 ^ bus.in2;
            OpSltu:  res = {{(WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
            OpLui:   res = bus.in2 << (WIDTH / 2);
            OpMfhi:  res = hi_q;
            OpMflo:  res = lo_q;
            default: res = '0;
        endcase
    end

    assign bus.res   = res;
    assign bus.stall = bus.in_valid && busy && is_md;
    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised bench for alu_muldiv at WIDTH=32 and WIDTH=16 against an arithmetic reference model.
// Both instances share stimulus; w selects which one is active and observed.
module tb_alu_muldiv;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  op;
    logic [63:0] a_drv;
    logic [63:0] b_drv;
    logic [5:0]  sh_drv;
    int          w;
    int          n_checks;
    int          n_errors;
    logic [63:0] m_hi;
    logic [63:0] m_lo;

    always #5 clk = ~clk;

    alu_muldiv_if #(.WIDTH(32)) if32 ();
    alu_muldiv_if #(.WIDTH(16)) if16 ();

    alu_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
    alu_muldiv #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));

    assign if32.in_valid = in_valid && (w == 32);
    assign if32.op       = op;
    assign if32.in1      = a_drv[31:0];
    assign if32.in2      = b_drv[31:0];
    assign if32.shamt    = sh_drv[4:0];
    assign if16.in_valid = in_valid && (w == 16);
    assign if16.op       = op;
    assign if16.in1      = a_drv[15:0];
    assign if16.in2      = b_drv[15:0];
    assign if16.shamt    = sh_drv[3:0];

    logic [63:0] o_res, o_hi, o_lo;
    logic        o_stall, o_busy, o_done;
    assign o_res   = (w == 32) ? {32'b0, if32.res} : {48'b0, if16.res};
    assign o_hi    = (w == 32) ? {32'b0, if32.hi}  : {48'b0, if16.hi};
    assign o_lo    = (w == 32) ? {32'b0, if32.lo}  : {48'b0, if16.lo};
    assign o_stall = (w == 32) ? if32.stall : if16.stall;
    assign o_busy  = (w == 32) ? if32.busy  : if16.busy;
    assign o_done  = (w == 32) ? if32.done  : if16.done;

    task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (w=%0d): got 0x%0h expected 0x%0h", tag, w, got, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(int wd);
        return (64'd1 << wd) - 64'd1;
    endfunction

    function automatic longint sext(logic [63:0] x, int wd);
        longint t;
        t = longint'(x << (64 - wd));
        return t >>> (64 - wd);
    endfunction

    function automatic logic [63:0] ref_alu(int wd, logic [4:0] o, logic [63:0] a, logic [63:0] b,
                                            int sh, logic [63:0] h, logic [63:0] l);
        logic [63:0] mk, r;
        longint      sa, sb;
        int          va;
        mk = mask_of(wd);
        sa = sext(a, wd);
        sb = sext(b, wd);
        va = int'(a & 64'(wd - 1));
        case (o)
            5'h01:   r = a + b;
            5'h02:   r = a & b;
            5'h03:   r = a | b;
            5'h04:   r = a - b;
            5'h05:   r = b << sh;
            5'h06:   r = (b & mk) >> sh;
            5'h07:   r = 64'(sb >>> sh);
            5'h08:   r = (sa < sb) ? 64'd1 : 64'd0;
            5'h09:   r = ~(a | b);
            5'h0A:   r = b << va;
            5'h0B:   r = (b & mk) >> va;
            5'h0C:   r = 64'(sb >>> va);
            5'h0D:   r = a ^ b;
            5'h0E:   r = ((a & mk) < (b & mk)) ? 64'd1 : 64'd0;
            5'h0F:   r = b << (wd / 2);
            5'h14:   r = h;
            5'h15:   r = l;
            default: r = 64'd0;
        endcase
        return r & mk;
    endfunction

    task automatic ref_muldiv(int wd, logic [4:0] o, logic [63:0] a, logic [63:0] b,
                              output logic [63:0] h, output logic [63:0] l);
        logic [63:0] mk, au, bu, pu;
        longint      sa, sb, p;
        mk = mask_of(wd);
        au = a & mk;
        bu = b & mk;
        sa = sext(au, wd);
        sb = sext(bu, wd);
        pu = 64'd0;
        if (o == 5'h10) begin
            p  = sa * sb;
            pu = 64'(p);
        end else if (o == 5'h11) begin
            pu = au * bu;
        end
        if (o == 5'h10 || o == 5'h11) begin
            h = (pu >> wd) & mk;
            l = pu & mk;
        end else if (bu == 64'd0) begin
            h = au;
            l = mk;
        end else if (o == 5'h12) begin
            h = 64'(sa % sb) & mk;
            l = 64'(sa / sb) & mk;
        end else begin
            h = au % bu;
            l = au / bu;
        end
    endtask

    function automatic int exp_lat(logic [4:0] o);
`ifdef ALU_FAST_MUL_EN
        if (o == 5'h10 || o == 5'h11) return 2;
`endif
        return w + 1;
    endfunction

    task automatic drive(logic v, logic [4:0] o, logic [63:0] a, logic [63:0] b, logic [5:0] s);
        in_valid = v;
        op       = o;
        a_drv    = a;
        b_drv    = b;
        sh_drv   = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'h0, 64'd0, 64'd0, 6'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 64'd0;
        m_lo = 64'd0;
    endtask

    task automatic single(string tag, logic [4:0] o, logic [63:0] a, logic [63:0] b, int sh,
                          logic has_lit, logic [63:0] lit);
        logic [63:0] mk;
        mk = mask_of(w);
        drive(1'b1, o, a & mk, b & mk, 6'(sh));
        #1;
        check_val(tag, o_res, ref_alu(w, o, a & mk, b & mk, sh, m_hi, m_lo));
        if (has_lit) check_val({tag, "_lit"}, o_res, lit);
        check_val({tag, "_nostall"}, 64'(o_stall), 64'd0);
        step();
        if (o == 5'h16) m_hi = a & mk;
        if (o == 5'h17) m_lo = a & mk;
        drive(1'b0, 5'h0, 64'd0, 64'd0, 6'd0);
    endtask

    task automatic run_muldiv(string tag, logic [4:0] o, logic [63:0] a, logic [63:0] b);
        logic [63:0] eh, el, mk;
        int          edges;
        mk = mask_of(w);
        ref_muldiv(w, o, a, b, eh, el);
        drive(1'b1, o, a & mk, b & mk, 6'd0);
        #1;
        check_val({tag, "_acc_stall"}, 64'(o_stall), 64'd0);
        step();
        drive(1'b0, 5'h0, 64'd0, 64'd0, 6'd0);
        edges = 0;
        while (!o_done && edges < 200) begin
            step();
            edges++;
        end
        check_val({tag, "_latency"}, 64'(edges), 64'(exp_lat(o)));
        check_val({tag, "_hi"}, o_hi, eh);
        check_val({tag, "_lo"}, o_lo, el);
        check_val({tag, "_busy"}, 64'(o_busy), 64'd0);
        m_hi = eh;
        m_lo = el;
        step();
        check_val({tag, "_done_pulse"}, 64'(o_done), 64'd0);
    endtask

    task automatic run_width();
        logic [63:0] mk, mn, old_lo, a1, b1, a2, b2, eh, el;
        logic [4:0]  o;
        int          n, edges, pulses;
        mk = mask_of(w);
        mn = 64'd1 << (w - 1);

        do_reset();
        check_val("rst_busy", 64'(o_busy), 64'd0);
        check_val("rst_done", 64'(o_done), 64'd0);
        check_val("rst_hi", o_hi, 64'd0);
        check_val("rst_lo", o_lo, 64'd0);

        single("sub", 5'h04, 64'd5, 64'd7, 0, 1'b1, mk - 64'd1);
        single("slt", 5'h08, mk, 64'd1, 0, 1'b1, 64'd1);
        single("sltu", 5'h0E, mk, 64'd1, 0, 1'b1, 64'd0);
        single("srav", 5'h0C, 64'h24, mn, 0, 1'b1, (mk << (w - 5)) & mk);
        single("lui", 5'h0F, 64'd0, 64'h1234, 0, 1'b1, (64'h1234 << (w / 2)) & mk);

        for (int i = 0; i < 60; i++) begin
            o = 5'($urandom_range(0, 31));
            if (o >= 5'h10 && o <= 5'h13) o = o + 5'd4;
            single("alu_rand", o, {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(0, w - 1)), 1'b0, 64'd0);
        end

        run_muldiv("mult", 5'h10, mk - 64'd2, 64'd7);
        check_val("mult_hi_lit", o_hi, mk);
        check_val("mult_lo_lit", o_lo, mk - 64'd20);
        run_muldiv("div", 5'h12, mk - 64'd6, 64'd2);
        check_val("div_lo_lit", o_lo, mk - 64'd2);
        check_val("div_hi_lit", o_hi, mk);
        run_muldiv("divu0", 5'h13, 64'd7, 64'd0);
        check_val("divu0_lo_lit", o_lo, mk);
        check_val("divu0_hi_lit", o_hi, 64'd7);
        run_muldiv("divovf", 5'h12, mn, mk);
        check_val("divovf_lo_lit", o_lo, mn);
        check_val("divovf_hi_lit", o_hi, 64'd0);

        for (int i = 0; i < 12; i++) begin
            o  = 5'h10 + 5'($urandom_range(0, 3));
            a1 = {$urandom, $urandom};
            b1 = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) b1 = b1 & 64'hFF;
            run_muldiv("md_rand", o, a1, b1);
        end

        // MFLO re-presented while a MULTU completes; ADD in between must never stall.
        old_lo = m_lo;
        drive(1'b1, 5'h11, 64'd3, 64'd4, 6'd0);
        step();
        drive(1'b1, 5'h01, 64'd1, 64'd2, 6'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("add_busy_stall", 64'(o_stall), 64'd0);
            check_val("add_busy_res", o_res, 64'd3);
            step();
        end
        drive(1'b1, 5'h15, 64'd0, 64'd0, 6'd0);
        n = 0;
        while (n < 100) begin
            #1;
            if (!o_busy) break;
            check_val("mflo_stall", 64'(o_stall), 64'd1);
            check_val("mflo_old", o_res, old_lo);
            step();
            n++;
        end
        check_val("mflo_bounded", 64'(n < 100), 64'd1);
        check_val("mflo_new", o_res, 64'd12);
        check_val("mflo_released", 64'(o_stall), 64'd0);
        m_hi = 64'd0;
        m_lo = 64'd12;
        step();
        drive(1'b0, 5'h0, 64'd0, 64'd0, 6'd0);

        // Back-to-back MULTU: the second is held stalled and accepted right after done.
        a1 = {$urandom, $urandom} & mk;
        b1 = {$urandom, $urandom} & mk;
        a2 = {$urandom, $urandom} & mk;
        b2 = {$urandom, $urandom} & mk;
        drive(1'b1, 5'h11, a1, b1, 6'd0);
        step();
        drive(1'b1, 5'h11, a2, b2, 6'd0);
        edges = 0;
        while (!o_done && edges < 200) begin
            step();
            edges++;
        end
        ref_muldiv(w, 5'h11, a1, b1, eh, el);
        check_val("b2b1_latency", 64'(edges), 64'(exp_lat(5'h11)));
        check_val("b2b1_hi", o_hi, eh);
        check_val("b2b1_lo", o_lo, el);
        check_val("b2b_accept_stall", 64'(o_stall), 64'd0);
        step();
        drive(1'b0, 5'h0, 64'd0, 64'd0, 6'd0);
        check_val("b2b2_busy", 64'(o_busy), 64'd1);
        edges = 0;
        while (!o_done && edges < 200) begin
            step();
            edges++;
        end
        ref_muldiv(w, 5'h11, a2, b2, eh, el);
        check_val("b2b2_latency", 64'(edges), 64'(exp_lat(5'h11)));
        check_val("b2b2_hi", o_hi, eh);
        check_val("b2b2_lo", o_lo, el);
        m_hi = eh;
        m_lo = el;
        step();

        // Reset in the middle of a DIV aborts it without touching HI/LO afterwards.
        drive(1'b1, 5'h12, mk - 64'd6, 64'd2, 6'd0);
        step();
        drive(1'b0, 5'h0, 64'd0, 64'd0, 6'd0);
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 64'd0;
        m_lo = 64'd0;
        check_val("abort_busy", 64'(o_busy), 64'd0);
        check_val("abort_hi", o_hi, 64'd0);
        check_val("abort_lo", o_lo, 64'd0);
        check_val("abort_done", 64'(o_done), 64'd0);
        pulses = 0;
        for (int i = 0; i < w + 8; i++) begin
            step();
            if (o_done) pulses++;
        end
        check_val("abort_no_done", 64'(pulses), 64'd0);
        drive(1'b1, 5'h16, 64'h55, 64'd0, 6'd0);
        step();
        drive(1'b0, 5'h0, 64'd0, 64'd0, 6'd0);
        check_val("mthi_after_abort", o_hi, 64'h55);
        check_val("mthi_lo_kept", o_lo, 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        w        = 32;
        reset    = 1'b0;
        drive(1'b0, 5'h0, 64'd0, 64'd0, 6'd0);
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 32 : 16;
            run_width();
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
